control_nibble_tx: RTL and testbench
====================================

CONTROL_NIBBLE_TX -- requirements
Module: control_nibble_tx

Interface
REQ-001 Parameter NIBBLES, default 8, gives the number of 4-bit nibbles per command word.
REQ-002 Parameter CFG_PULSE_CYCLES, default 4, gives the start_config pulse length in clocks (minimum 1).
REQ-003 clk_125  input  1  sole clock; all logic is on its rising edge.
REQ-004 sys_rst_n  input  1  asynchronous, active-low reset.
REQ-005 cmd_data  input  4*NIBBLES  command word to send; MSB nibble goes first.
REQ-006 cmd_cfg  input  1  request a start_config pulse after the word completes.
REQ-007 cmd_valid  input  1  command word offered.
REQ-008 cmd_ready  output  1  block accepts a command word this cycle.
REQ-009 control_data  output  4  nibble presented to the control sink.
REQ-010 control_valid  output  1  control_data valid.
REQ-011 control_ready  input  1  sink accepts the nibble this cycle.
REQ-012 start_config  output  1  configuration-start pulse to the sink.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 words_sent  output  16  count of fully transmitted words.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SEND and CFG.
REQ-016 cmd_ready SHALL be 1 only in IDLE; a word is accepted on a cycle where cmd_valid and cmd_ready are both high.
REQ-017 On accept, the block SHALL latch cmd_data into a shift register, latch cmd_cfg, load the nibble count with NIBBLES, and enter SEND.
REQ-018 control_valid SHALL be registered and high in SEND only; for an accept on cycle N, the first nibble is valid on cycle N+1.
REQ-019 control_data SHALL equal the top nibble of the shift register while control_valid is high, and 4'h0 otherwise.
REQ-020 Once control_valid is high, control_valid and control_data SHALL hold stable until a cycle where control_ready is also high.
REQ-021 On each nibble transfer (control_valid and control_ready high), the shift register SHALL shift left by 4 and the count SHALL decrement by 1.
REQ-022 On the transfer of the last nibble, words_sent SHALL increment, wrapping from 16'hFFFF to 16'h0000.
REQ-023 After the last nibble, the FSM SHALL go to CFG if the latched cfg bit is 1, otherwise to IDLE.
REQ-024 In CFG, start_config SHALL be high for exactly CFG_PULSE_CYCLES consecutive cycles; the FSM SHALL then return to IDLE, and start_config SHALL be 0 elsewhere.
REQ-025 Consecutive words SHALL be separated by at least one IDLE cycle; cmd_valid held high is accepted on the first IDLE cycle.
REQ-026 control_ready held low indefinitely SHALL stall the block in SEND with outputs frozen; no timeout applies.
REQ-027 control_ready high while control_valid is low SHALL have no effect.

Reset
REQ-028 While sys_rst_n is low, the block SHALL hold: state = IDLE, cmd_ready = 0, control_valid = 0, control_data = 0, start_config = 0, busy = 0, words_sent = 0, and the shift register and count cleared.
REQ-029 cmd_ready SHALL first rise on the first clk_125 edge after sys_rst_n deasserts; deassertion is synchronous to clk_125, provided by the upstream synchronizer.
REQ-030 Reset asserted in SEND or CFG SHALL discard the partial word or pulse immediately, with no increment of words_sent.

Structure
REQ-031 The package control_nibble_pkg SHALL hold the state enum (IDLE/SEND/CFG) and the constant NIBBLE_W = 4.
REQ-032 The block SHALL have no sub-module; the pulse counter and nibble counter are inline.

Verification
REQ-033 Word 32'h1234_ABCD, cmd_cfg=0, control_ready=1 -> nibbles 1,2,3,4,A,B,C,D on 8 consecutive cycles starting at N+1; words_sent=1; start_config never high.
REQ-034 Same word with control_ready low for 3 cycles at nibble 5 -> control_data holds 4'hA with control_valid high for the 3 stall cycles; sequence otherwise unchanged.
REQ-035 cmd_cfg=1 -> start_config high for exactly 4 cycles immediately after nibble D; cmd_ready high on the following cycle.
REQ-036 sys_rst_n low after the 3rd nibble -> all outputs return to reset values the same cycle; the next word transmits from nibble 1; words_sent=0.
REQ-037 words_sent preloaded by sending 65535 words, then one more -> words_sent = 0.
REQ-038 cmd_valid held high with 2 queued words -> exactly 1 IDLE cycle between the last nibble of word 1 and the accept of word 2.

Source files
------------

// File: rtl/control_nibble_tx_pkg.sv
// Shared types and constants for the control nibble transmitter.
package control_nibble_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CFG  = 2'd2
  } state_e;

endpackage

// File: rtl/control_nibble_tx_if.sv
// Command-side and control-sink-side signals of the nibble transmitter.
interface control_nibble_tx_if #(
  parameter int NIBBLES = 8
);
  import control_nibble_pkg::*;

  logic [NIBBLE_W*NIBBLES-1:0] cmd_data;
  logic                        cmd_cfg;
  logic                        cmd_valid;
  logic                        cmd_ready;
  logic [NIBBLE_W-1:0]         control_data;
  logic                        control_valid;
  logic                        control_ready;
  logic                        start_config;
  logic                        busy;
  logic [15:0]                 words_sent;

  modport master (
    output cmd_data, cmd_cfg, cmd_valid, control_ready,
    input  cmd_ready, control_data, control_valid, start_config, busy, words_sent
  );

  modport slave (
    input  cmd_data, cmd_cfg, cmd_valid, control_ready,
    output cmd_ready, control_data, control_valid, start_config, busy, words_sent
  );

endinterface

// File: rtl/control_nibble_tx.sv
// Serialises a command word MSB-nibble-first onto a valid/ready control sink,
// optionally followed by a fixed-length start_config pulse.
module control_nibble_tx
  import control_nibble_pkg::*;
#(
  parameter int NIBBLES          = 8,
  parameter int CFG_PULSE_CYCLES = 4
) (
  input  logic               clk_125,
  input  logic               sys_rst_n,
  control_nibble_tx_if.slave bus
);

  localparam int WORD_W  = NIBBLE_W * NIBBLES;
  localparam int CNT_W   = $clog2(NIBBLES + 1);
  localparam int PULSE_W = (CFG_PULSE_CYCLES > 1) ? $clog2(CFG_PULSE_CYCLES) : 1;

  state_e             state;
  logic [WORD_W-1:0]  shift_q;
  logic [WORD_W-1:0]  shift_nxt;
  logic               cfg_q;
  logic [CNT_W-1:0]   nib_cnt;
  logic [PULSE_W-1:0] pulse_cnt;
  logic               xfer;
  logic               last_nib;

  assign shift_nxt = shift_q << NIBBLE_W;
  assign xfer      = bus.control_valid && bus.control_ready;
  assign last_nib  = (nib_cnt == CNT_W'(1));

  // All outputs are registered; each transition sets the values for the next state.
  always_ff @(posedge clk_125 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state             <= IDLE;
      shift_q           <= '0;
      cfg_q             <= 1'b0;
      nib_cnt           <= '0;
      pulse_cnt         <= '0;
      bus.cmd_ready     <= 1'b0;
      bus.control_valid <= 1'b0;
      bus.control_data  <= '0;
      bus.start_config  <= 1'b0;
      bus.busy          <= 1'b0;
      bus.words_sent    <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            shift_q           <= bus.cmd_data;
            cfg_q             <= bus.cmd_cfg;
            nib_cnt           <= CNT_W'(NIBBLES);
            bus.control_data  <= bus.cmd_data[WORD_W-1 -: NIBBLE_W];
            bus.control_valid <= 1'b1;
            bus.cmd_ready     <= 1'b0;
            bus.busy          <= 1'b1;
            state             <= SEND;
          end else begin
            // Ready only rises on the first edge after reset release.
            bus.cmd_ready <= 1'b1;
          end
        end

        SEND: begin
          if (xfer) begin
            shift_q <= shift_nxt;
            nib_cnt <= nib_cnt - 1'b1;
            if (last_nib) begin
              bus.control_valid <= 1'b0;
              bus.control_data  <= '0;
              bus.words_sent    <= bus.words_sent + 16'd1;
              if (cfg_q) begin
                bus.start_config <= 1'b1;
                pulse_cnt        <= PULSE_W'(CFG_PULSE_CYCLES - 1);
                state            <= CFG;
              end else begin
                bus.cmd_ready <= 1'b1;
                bus.busy      <= 1'b0;
                state         <= IDLE;
              end
            end else begin
              bus.control_data <= shift_nxt[WORD_W-1 -: NIBBLE_W];
            end
          end
        end

        CFG: begin
          if (pulse_cnt == '0) begin
            bus.start_config <= 1'b0;
            bus.cmd_ready    <= 1'b1;
            bus.busy         <= 1'b0;
            state            <= IDLE;
          end else begin
            pulse_cnt <= pulse_cnt - 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_control_nibble_tx.sv
// Directed bench for control_nibble_tx: nibble order, stalls, config pulse,
// back-to-back words, mid-word reset and words_sent wrap.
module tb_control_nibble_tx;

  localparam int NIBBLES = 8;
  localparam int CFG_N   = 4;

  logic clk_125   = 1'b0;
  logic sys_rst_n = 1'b0;

  control_nibble_tx_if #(.NIBBLES(NIBBLES)) ifc ();

  control_nibble_tx #(
    .NIBBLES          (NIBBLES),
    .CFG_PULSE_CYCLES (CFG_N)
  ) dut (
    .clk_125   (clk_125),
    .sys_rst_n (sys_rst_n),
    .bus       (ifc)
  );

  always #4 clk_125 = ~clk_125;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_125);
    #1;
  endtask

  // Sends one word with control_ready high, except a 3-cycle stall at nibble stall_at.
  task automatic send_word(input logic [31:0] w, input logic cfg, input int stall_at);
    int guard;
    logic [3:0] exp_n;
    guard = 0;
    while (ifc.cmd_ready !== 1'b1 && guard < 40) begin
      tick();
      guard++;
    end
    chk("ready_before_accept", 32'(ifc.cmd_ready), 32'd1);
    ifc.cmd_data      = w;
    ifc.cmd_cfg       = cfg;
    ifc.cmd_valid     = 1'b1;
    ifc.control_ready = 1'b1;
    tick();
    ifc.cmd_valid = 1'b0;
    for (int i = 0; i < NIBBLES; i++) begin
      exp_n = w[31-4*i -: 4];
      if (i == stall_at) begin
        ifc.control_ready = 1'b0;
        repeat (3) begin
          chk("stall_valid", 32'(ifc.control_valid), 32'd1);
          chk("stall_data", 32'(ifc.control_data), 32'(exp_n));
          tick();
        end
        ifc.control_ready = 1'b1;
      end
      chk($sformatf("nib%0d_valid", i), 32'(ifc.control_valid), 32'd1);
      chk($sformatf("nib%0d_data", i), 32'(ifc.control_data), 32'(exp_n));
      chk($sformatf("nib%0d_cfg_low", i), 32'(ifc.start_config), 32'd0);
      tick();
    end
    chk("post_word_valid", 32'(ifc.control_valid), 32'd0);
    chk("post_word_data", 32'(ifc.control_data), 32'd0);
  endtask

  initial begin
    logic [31:0] w1;
    logic [31:0] w2;
    w1 = 32'h1234_ABCD;
    w2 = 32'h89AB_CDEF;
    ifc.cmd_data      = '0;
    ifc.cmd_cfg       = 1'b0;
    ifc.cmd_valid     = 1'b0;
    ifc.control_ready = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_cmd_ready", 32'(ifc.cmd_ready), 32'd0);
    chk("rst_valid", 32'(ifc.control_valid), 32'd0);
    chk("rst_data", 32'(ifc.control_data), 32'd0);
    chk("rst_start_config", 32'(ifc.start_config), 32'd0);
    chk("rst_busy", 32'(ifc.busy), 32'd0);
    chk("rst_words", 32'(ifc.words_sent), 32'd0);

    ifc.control_ready = 1'b1;
    sys_rst_n = 1'b1;
    #1;
    chk("ready_before_first_edge", 32'(ifc.cmd_ready), 32'd0);
    tick();
    chk("ready_after_release", 32'(ifc.cmd_ready), 32'd1);
    chk("idle_ready_no_effect", 32'(ifc.control_valid), 32'd0);
    chk("idle_busy", 32'(ifc.busy), 32'd0);

    // Plain word
    send_word(w1, 1'b0, -1);
    chk("w1_words", 32'(ifc.words_sent), 32'd1);
    chk("w1_ready", 32'(ifc.cmd_ready), 32'd1);
    chk("w1_busy", 32'(ifc.busy), 32'd0);
    chk("w1_no_cfg", 32'(ifc.start_config), 32'd0);

    // Stall at nibble A
    send_word(w1, 1'b0, 4);
    chk("stall_words", 32'(ifc.words_sent), 32'd2);

    // Config pulse
    send_word(w1, 1'b1, -1);
    chk("cfg_words", 32'(ifc.words_sent), 32'd3);
    for (int k = 0; k < CFG_N; k++) begin
      chk($sformatf("cfg%0d_pulse", k), 32'(ifc.start_config), 32'd1);
      chk($sformatf("cfg%0d_ready", k), 32'(ifc.cmd_ready), 32'd0);
      chk($sformatf("cfg%0d_busy", k), 32'(ifc.busy), 32'd1);
      tick();
    end
    chk("cfg_end_pulse", 32'(ifc.start_config), 32'd0);
    chk("cfg_end_ready", 32'(ifc.cmd_ready), 32'd1);
    chk("cfg_end_busy", 32'(ifc.busy), 32'd0);

    // Back-to-back words with cmd_valid held high
    ifc.cmd_data      = w1;
    ifc.cmd_cfg       = 1'b0;
    ifc.cmd_valid     = 1'b1;
    ifc.control_ready = 1'b1;
    tick();
    ifc.cmd_data = w2;
    for (int i = 0; i < NIBBLES; i++) begin
      chk($sformatf("b2b_w1_nib%0d", i), 32'(ifc.control_data), 32'(w1[31-4*i -: 4]));
      chk($sformatf("b2b_w1_ready%0d", i), 32'(ifc.cmd_ready), 32'd0);
      tick();
    end
    chk("b2b_gap_valid", 32'(ifc.control_valid), 32'd0);
    chk("b2b_gap_ready", 32'(ifc.cmd_ready), 32'd1);
    chk("b2b_gap_busy", 32'(ifc.busy), 32'd0);
    tick();
    ifc.cmd_valid = 1'b0;
    for (int i = 0; i < NIBBLES; i++) begin
      chk($sformatf("b2b_w2_valid%0d", i), 32'(ifc.control_valid), 32'd1);
      chk($sformatf("b2b_w2_nib%0d", i), 32'(ifc.control_data), 32'(w2[31-4*i -: 4]));
      tick();
    end
    chk("b2b_words", 32'(ifc.words_sent), 32'd5);

    // Reset in the middle of a word
    ifc.cmd_data  = w1;
    ifc.cmd_valid = 1'b1;
    tick();
    ifc.cmd_valid = 1'b0;
    repeat (3) tick();
    chk("pre_rst_nib4", 32'(ifc.control_data), 32'h4);
    sys_rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(ifc.control_valid), 32'd0);
    chk("midrst_data", 32'(ifc.control_data), 32'd0);
    chk("midrst_ready", 32'(ifc.cmd_ready), 32'd0);
    chk("midrst_busy", 32'(ifc.busy), 32'd0);
    chk("midrst_cfg", 32'(ifc.start_config), 32'd0);
    chk("midrst_words", 32'(ifc.words_sent), 32'd0);
    tick();
    sys_rst_n = 1'b1;
    tick();
    chk("postrst_ready", 32'(ifc.cmd_ready), 32'd1);
    send_word(w1, 1'b0, -1);
    chk("postrst_words", 32'(ifc.words_sent), 32'd1);

    // words_sent wrap, starting from a preloaded count
    force ifc.words_sent = 16'hFFFE;
    #1;
    release ifc.words_sent;
    #1;
    chk("preload_words", 32'(ifc.words_sent), 32'h0000_FFFE);
    send_word(w2, 1'b0, -1);
    chk("wrap_ffff", 32'(ifc.words_sent), 32'h0000_FFFF);
    send_word(w2, 1'b0, -1);
    chk("wrap_zero", 32'(ifc.words_sent), 32'h0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, expected finish before 200000ns");
    $fatal(1, "timeout");
  end

endmodule
